// File: rtl/memory_access_if.sv
// Bus bundle between the EX/MEM pipeline register and the MEM stage outputs toward write-back.
interface memory_access_if #(
  parameter int unsigned NB_REG = 32,
  parameter int unsigned NB_MEM = 5,
  parameter int unsigned NB_WB  = 8
);
  logic              i_valid;
  logic [NB_REG-1:0] i_alu;
  logic [NB_REG-1:0] i_b;
  logic [NB_MEM-1:0] i_mem;
  logic [NB_WB-1:0]  i_wb;
  logic [NB_REG-1:0] o_rdata;
  logic [NB_REG-1:0] o_alu;
  logic [NB_WB-1:0]  o_wb;
  logic              o_misaligned;

  modport master (
    output i_valid, i_alu, i_b, i_mem, i_wb,
    input  o_rdata, o_alu, o_wb, o_misaligned
  );

  modport slave (
    input  i_valid, i_alu, i_b, i_mem, i_wb,
    output o_rdata, o_alu, o_wb, o_misaligned
  );
endinterface

// File: rtl/memory_access.sv
// MIPS MEM stage: byte/half/word loads and stores on a word-organised data memory,
// plus the MEM/WB pipeline register.
module memory_access #(
  parameter int unsigned NB_REG  = 32,
  parameter int unsigned NB_MEM  = 5,
  parameter int unsigned NB_WB   = 8,
  parameter int unsigned NB_ADDR = 10
) (
  input  logic              i_clock,
  input  logic              i_reset,
  memory_access_if.slave    bus
);

  localparam int unsigned DEPTH   = 2 ** NB_ADDR;
  localparam int unsigned NB_LANE = 4;
  localparam logic [1:0]  SZ_B    = 2'b00;
  localparam logic [1:0]  SZ_H    = 2'b01;

  logic [NB_REG-1:0] mem_q [DEPTH];

  logic [NB_REG-1:0] rdata_q, rdata_d;
  logic [NB_REG-1:0] alu_q,   alu_d;
  logic [NB_WB-1:0]  wb_q,    wb_d;
  logic              mis_q,   mis_d;

  logic               rd, wr, uns;
  logic [1:0]         size;
  logic [1:0]         lane;
  logic [NB_ADDR-1:0] idx;
  logic [NB_REG-1:0]  word_rd;
  logic [7:0]         byte_rd;
  logic [15:0]        half_rd;
  logic               fault;
  logic [NB_REG-1:0]  load_val;
  logic [NB_LANE-1:0] be;
  logic [NB_REG-1:0]  wdata;
  logic               unused_addr_bits;

  assign rd   = bus.i_mem[4];
  assign wr   = bus.i_mem[3];
  assign uns  = bus.i_mem[2];
  assign size = bus.i_mem[1:0];
  assign lane = bus.i_alu[1:0];
  assign idx  = bus.i_alu[NB_ADDR+1:2];

  // Upper address bits alias onto the same words.
  assign unused_addr_bits = ^bus.i_alu[NB_REG-1:NB_ADDR+2];

  // Pre-edge read gives read-before-write semantics.
  assign word_rd = mem_q[idx];
  assign byte_rd = 8'(word_rd >> {lane, 3'b000});
  assign half_rd = lane[1] ? word_rd[31:16] : word_rd[15:0];

  always_comb begin
    fault    = 1'b0;
    load_val = '0;
    be       = '0;
    wdata    = bus.i_b;

    if (rd || wr) begin
      case (size)
        SZ_B:    fault = 1'b0;
        SZ_H:    fault = lane[0];
        default: fault = (lane != 2'b00);
      endcase
    end

    if (rd && !wr && !fault) begin
      case (size)
        SZ_B:    load_val = uns ? NB_REG'(byte_rd) : {{(NB_REG-8){byte_rd[7]}}, byte_rd};
        SZ_H:    load_val = uns ? NB_REG'(half_rd) : {{(NB_REG-16){half_rd[15]}}, half_rd};
        default: load_val = word_rd;
      endcase
    end

    if (bus.i_valid && wr && !fault) begin
      case (size)
        SZ_B: begin
          be    = NB_LANE'(4'b0001 << lane);
          wdata = NB_REG'({4{bus.i_b[7:0]}});
        end
        SZ_H: begin
          be    = lane[1] ? 4'b1100 : 4'b0011;
          wdata = NB_REG'({2{bus.i_b[15:0]}});
        end
        default: be = 4'b1111;
      endcase
    end
  end

  // Pipeline register next-state; a stall holds every output.
  always_comb begin
    rdata_d = rdata_q;
    alu_d   = alu_q;
    wb_d    = wb_q;
    mis_d   = mis_q;
    if (bus.i_valid) begin
      rdata_d = load_val;
      alu_d   = bus.i_alu;
      wb_d    = bus.i_wb;
      mis_d   = fault;
    end
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      rdata_q <= '0;
      alu_q   <= '0;
      wb_q    <= '0;
      mis_q   <= 1'b0;
    end else begin
      rdata_q <= rdata_d;
      alu_q   <= alu_d;
      wb_q    <= wb_d;
      mis_q   <= mis_d;
    end
  end

  // Memory keeps its contents across reset; an edge seen while in reset never writes.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      for (int l = 0; l < NB_LANE; l++) begin
        if (be[l]) mem_q[idx][8*l +: 8] <= wdata[8*l +: 8];
      end
    end
  end

  assign bus.o_rdata      = rdata_q;
  assign bus.o_alu        = alu_q;
  assign bus.o_wb         = wb_q;
  assign bus.o_misaligned = mis_q;

endmodule
